ed_pipe_stats: RTL and testbench

//  Pipelined, parametrised successor of the combinational 3x3 edge classifier in the

---
 rtl/ed_pipe_stats.sv | 188 ++++++++++++++++++
 tb/tb_ed_pipe_stats.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ed_pipe_stats.sv
// Pipelined 3x3 edge classifier with valid/ready flow control.
// It keeps per-frame counts of each edge class.
module ed_pipe_stats #(
  parameter int DATA_W         = 8,
  parameter int CNT_W          = 20,
  parameter int THRESH_DEFAULT = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_p1,
  input  logic [DATA_W-1:0] in_p2,
  input  logic [DATA_W-1:0] in_p3,
  input  logic [DATA_W-1:0] in_p4,
  input  logic [DATA_W-1:0] in_p6,
  input  logic [DATA_W-1:0] in_p7,
  input  logic [DATA_W-1:0] in_p8,
  input  logic [DATA_W-1:0] in_p9,
  input  logic              in_eof,
  input  logic              thr_wr,
  input  logic [DATA_W-1:0] thr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        ed_class,
  output logic [3:0]        dir_mask,
  output logic              out_eof,
  output logic              stat_valid,
  output logic [CNT_W-1:0]  stat_diag,
  output logic [CNT_W-1:0]  stat_vh,
  output logic [CNT_W-1:0]  stat_none
);

  typedef logic [DATA_W-1:0] px_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    logic           v;
    logic           eof;
    px_t            thr;
    logic [3:0][DATA_W-1:0] d;
  } s1_t;

  typedef struct packed {
    logic       v;
    logic       eof;
    logic [3:0] m;
  } s2_t;

  typedef struct packed {
    logic       v;
    logic       eof;
    logic [1:0] cls;
    logic [3:0] m;
  } s3_t;

  localparam px_t THR_RST = px_t'(THRESH_DEFAULT);

  function automatic px_t absd(input px_t a, input px_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic cnt_t sat_inc(input cnt_t c);
    return (&c) ? c : c + 1'b1;
  endfunction

  s1_t s1;
  s2_t s2;
  s3_t s3;

  px_t thr_act;
  px_t thr_pend;

  cnt_t cnt_diag, cnt_vh, cnt_none;
  cnt_t diag_nx, vh_nx, none_nx;

  logic       en;
  logic       acc;
  logic       handoff;
  logic [3:0] mask_nx;
  logic [1:0] cls_nx;

  assign en       = out_ready || !s3.v;
  assign in_ready = en && rst_n;
  assign acc      = in_valid && in_ready;
  assign handoff  = s3.v && out_ready;

  assign out_valid = s3.v;
  assign ed_class  = s3.cls;
  assign dir_mask  = s3.m;
  assign out_eof   = s3.eof;

  always_comb begin
    mask_nx = '0;
    for (int i = 0; i < 4; i++) begin
      mask_nx[i] = (s1.d[i] >= s1.thr);
    end
  end

  // Diagonal wins over vertical/horizontal.
  always_comb begin
    cls_nx = 2'b00;
    if (|s2.m[1:0]) begin
      cls_nx = 2'b10;
    end else if (|s2.m[3:2]) begin
      cls_nx = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (en) begin
      s1.v    <= in_valid;
      s1.eof  <= in_eof;
      s1.thr  <= thr_act;
      s1.d[0] <= absd(in_p1, in_p9);
      s1.d[1] <= absd(in_p3, in_p7);
      s1.d[2] <= absd(in_p4, in_p6);
      s1.d[3] <= absd(in_p2, in_p8);
      s2.v    <= s1.v;
      s2.eof  <= s1.eof;
      s2.m    <= mask_nx;
      s3.v    <= s2.v;
      s3.eof  <= s2.eof;
      s3.m    <= s2.m;
      s3.cls  <= cls_nx;
    end
  end

  // The eof beat keeps the old threshold; the frame after it sees the new one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_act  <= THR_RST;
      thr_pend <= THR_RST;
    end else begin
      if (thr_wr) begin
        thr_pend <= thr_in;
      end
      if (acc && in_eof) begin
        thr_act <= thr_wr ? thr_in : thr_pend;
      end
    end
  end

  always_comb begin
    diag_nx = cnt_diag;
    vh_nx   = cnt_vh;
    none_nx = cnt_none;
    if (handoff) begin
      unique case (s3.cls)
        2'b10:   diag_nx = sat_inc(cnt_diag);
        2'b01:   vh_nx   = sat_inc(cnt_vh);
        default: none_nx = sat_inc(cnt_none);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_diag   <= '0;
      cnt_vh     <= '0;
      cnt_none   <= '0;
      stat_diag  <= '0;
      stat_vh    <= '0;
      stat_none  <= '0;
      stat_valid <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (handoff && s3.eof) begin
        stat_diag  <= diag_nx;
        stat_vh    <= vh_nx;
        stat_none  <= none_nx;
        stat_valid <= 1'b1;
        cnt_diag   <= '0;
        cnt_vh     <= '0;
        cnt_none   <= '0;
      end else begin
        cnt_diag <= diag_nx;
        cnt_vh   <= vh_nx;
        cnt_none <= none_nx;
      end
    end
  end

endmodule

// File: tb/tb_ed_pipe_stats.sv
// Bench for ed_pipe_stats: directed cases plus random traffic
// checked against a beat-queue reference model.
module tb_ed_pipe_stats;

  localparam int DW = 8;
  localparam int CW = 20;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] pv [1:9];
  logic          in_eof = 1'b0;
  logic          thr_wr = 1'b0;
  logic [DW-1:0] thr_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [1:0]    ed_class;
  logic [3:0]    dir_mask;
  logic          out_eof;
  logic          stat_valid;
  logic [CW-1:0] stat_diag, stat_vh, stat_none;

  always #5 clk = ~clk;

  ed_pipe_stats #(.DATA_W(DW), .CNT_W(CW), .THRESH_DEFAULT(80)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p1(pv[1]), .in_p2(pv[2]), .in_p3(pv[3]), .in_p4(pv[4]),
    .in_p6(pv[6]), .in_p7(pv[7]), .in_p8(pv[8]), .in_p9(pv[9]),
    .in_eof(in_eof), .thr_wr(thr_wr), .thr_in(thr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .ed_class(ed_class), .dir_mask(dir_mask), .out_eof(out_eof),
    .stat_valid(stat_valid), .stat_diag(stat_diag),
    .stat_vh(stat_vh), .stat_none(stat_none)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int cls;
    int mask;
    int eof;
  } beat_t;

  beat_t q[$];
  int    thr_a = 80;
  int    thr_p = 80;
  int    cnt[3];
  int    st[3];
  int    sv_m = 0;
  bit    mon_en = 1'b0;
  bit    prev_stall = 1'b0;
  logic [7:0] prev_out;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic beat_t ref_beat(input int thr, input int eof);
    beat_t b;
    int d[4];
    d[0] = iabs(int'(pv[1]) - int'(pv[9]));
    d[1] = iabs(int'(pv[3]) - int'(pv[7]));
    d[2] = iabs(int'(pv[4]) - int'(pv[6]));
    d[3] = iabs(int'(pv[2]) - int'(pv[8]));
    b.mask = 0;
    for (int i = 0; i < 4; i++) begin
      if (d[i] >= thr) b.mask += (1 << i);
    end
    if ((b.mask & 3) != 0)       b.cls = 2;
    else if ((b.mask & 12) != 0) b.cls = 1;
    else                         b.cls = 0;
    b.eof = eof;
    return b;
  endfunction

  // Model state describes what the DUT registers hold after the next edge.
  always @(negedge clk) begin
    beat_t b;
    if (mon_en) begin
      check("stat_valid", stat_valid, sv_m);
      check("stat_diag", stat_diag, st[2]);
      check("stat_vh", stat_vh, st[1]);
      check("stat_none", stat_none, st[0]);
      check("in_ready", in_ready, rst_n && (out_ready || !out_valid));
      if (prev_stall)
        check("hold", {out_valid, ed_class, dir_mask, out_eof}, prev_out);
      prev_stall = rst_n && out_valid && !out_ready;
      prev_out   = {out_valid, ed_class, dir_mask, out_eof};
      if (!rst_n) begin
        q.delete();
        cnt   = '{0, 0, 0};
        st    = '{0, 0, 0};
        sv_m  = 0;
        thr_a = 80;
        thr_p = 80;
      end else begin
        sv_m = 0;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("spurious_out", 1, 0);
          end else begin
            b = q.pop_front();
            check("out_class", ed_class, b.cls);
            check("out_mask", dir_mask, b.mask);
            check("out_eof", out_eof, b.eof);
            if (cnt[b.cls] < CMAX) cnt[b.cls]++;
            if (b.eof != 0) begin
              st   = cnt;
              sv_m = 1;
              cnt  = '{0, 0, 0};
            end
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(ref_beat(thr_a, int'(in_eof)));
          if (in_eof) thr_a = thr_wr ? int'(thr_in) : thr_p;
        end
        if (thr_wr) thr_p = int'(thr_in);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int i = 1; i <= 9; i++) pv[i] = 8'(v);
  endtask

  task automatic set_cls(input int c);
    set_all(50);
    if (c == 2) begin
      pv[1] = 200;
      pv[9] = 100;
    end else if (c == 1) begin
      pv[2] = 0;
      pv[8] = 90;
    end
  endtask

  task automatic send(input bit eof, input bit w, input int t);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_eof   = eof;
    thr_wr   = w;
    thr_in   = 8'(t);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_eof   = 1'b0;
    thr_wr   = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic get_out(output int cls, output int mask, output int eo);
    bit hit = 1'b0;
    cls  = -1;
    mask = -1;
    eo   = -1;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        hit  = 1'b1;
        cls  = int'(ed_class);
        mask = int'(dir_mask);
        eo   = int'(out_eof);
      end
    end
    tick();
    if (!hit) check("out_timeout", 0, 1);
  endtask

  task automatic wait_stat;
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = stat_valid;
    end
    check("stat_seen", hit, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int c, m, e;
    int exp_cls[10];
    set_all(0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_class", ed_class, 0);
    check("rst_stat_diag", stat_diag, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // latency
    set_cls(0);
    pv[1] = 200;
    pv[9] = 100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_c1", out_valid, 0);
    tick();
    check("lat_c2", out_valid, 0);
    tick();
    check("lat_c3_valid", out_valid, 1);
    check("lat_class", ed_class, 2);
    check("lat_mask", dir_mask, 1);
    tick();

    // priority
    out_ready = 1'b0;
    set_all(50);
    pv[4] = 0;   pv[6] = 255;
    pv[3] = 180; pv[7] = 90;
    send(0, 0, 0);
    set_all(50);
    pv[2] = 100; pv[8] = 20;
    send(0, 0, 0);
    pv[2] = 99;
    send(0, 0, 0);
    out_ready = 1'b1;
    get_out(c, m, e);
    check("prio_diag_cls", c, 2);
    check("prio_diag_mask", m, 6);
    get_out(c, m, e);
    check("prio_vh_cls", c, 1);
    check("prio_vh_mask", m, 8);
    get_out(c, m, e);
    check("prio_none_cls", c, 0);
    check("prio_none_mask", m, 0);

    // backpressure burst
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          for (int j = 1; j <= 9; j++) pv[j] = 8'($urandom_range(0, 255));
          send(0, 0, 0);
        end
      end
      begin
        repeat (5) tick();
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    repeat (8) tick();
    check("bp_drain", q.size(), 0);

    // threshold switch
    thr_in = 20;
    thr_wr = 1'b1;
    tick();
    thr_wr = 1'b0;
    out_ready = 1'b0;
    set_all(50);
    pv[1] = 80;
    send(0, 0, 0);
    send(1, 0, 0);
    send(0, 0, 0);
    out_ready = 1'b1;
    get_out(c, m, e);
    check("thr_pre_cls", c, 0);
    get_out(c, m, e);
    check("thr_eof_cls", c, 0);
    check("thr_eof_flag", e, 1);
    get_out(c, m, e);
    check("thr_new_cls", c, 2);
    check("thr_new_mask", m, 1);

    // mid-frame reset
    out_ready = 1'b0;
    set_cls(2);
    send(0, 0, 0);
    send(0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mrst_out_valid", out_valid, 0);
    check("mrst_stat_none", stat_none, 0);
    repeat (4) tick();
    check("mrst_no_out", out_valid, 0);

    // 10-pixel frame statistics
    exp_cls = '{2, 0, 1, 0, 2, 0, 1, 0, 0, 2};
    for (int i = 0; i < 10; i++) begin
      set_cls(exp_cls[i]);
      send(i == 9, 0, 0);
    end
    wait_stat();
    check("frm_diag", stat_diag, 3);
    check("frm_vh", stat_vh, 2);
    check("frm_none", stat_none, 5);
    set_cls(0);
    send(1, 0, 0);
    wait_stat();
    check("frm1_none", stat_none, 1);
    check("frm1_diag", stat_diag, 0);

    // back-to-back eof, then zero threshold
    set_cls(2);
    send(1, 0, 0);
    set_cls(1);
    send(1, 0, 0);
    repeat (5) tick();
    out_ready = 1'b0;
    set_all(50);
    send(1, 1, 0);
    send(0, 0, 0);
    out_ready = 1'b1;
    get_out(c, m, e);
    check("thr0_eof_cls", c, 0);
    get_out(c, m, e);
    check("thr0_cls", c, 2);
    check("thr0_mask", m, 15);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      int base;
      base = $urandom_range(0, 255);
      for (int j = 1; j <= 9; j++)
        pv[j] = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'(base);
      rst_n     = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_eof    = ($urandom_range(0, 9) == 0);
      thr_wr    = ($urandom_range(0, 15) == 0);
      thr_in    = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 120));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    in_eof    = 1'b0;
    thr_wr    = 1'b0;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (10) tick();
    check("final_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
